// File: rtl/rx_pkg.sv
// Shared types and default constants for the AWGN receive detector.
//   rx_state_t : frame FSM states (HUNT for the sync word, LOCK while packing payload)
//   DEF_*      : default parameter values used by the top and the integrator
package rx_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } rx_state_t;

    localparam int unsigned SAMPLE_W          = 16;
    localparam int unsigned DEF_SPS           = 8;
    localparam int unsigned DEF_ACC_W         = 19;
    localparam int unsigned DEF_SYNC_W        = 16;
    localparam logic [15:0] DEF_SYNC_WORD     = 16'hA5F0;
    localparam int unsigned DEF_PAYLOAD_BYTES = 4;
    localparam int unsigned BYTE_W            = 8;

endpackage

// File: rtl/integrate_dump.sv
// Integrate-and-dump symbol slicer: sums SPS signed samples, then decides
// the antipodal bit from the sign of the total (zero counts as a 1).
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous flush of accumulator/counter; sample on this edge is discarded
//   sample_in    : signed 16-bit sample, accepted when sample_valid is high
//   bit_out      : decided bit, held until the next decision
//   bit_valid    : one-cycle pulse after the edge that accepted the last sample of a symbol
module integrate_dump
    import rx_pkg::*;
#(
    parameter int unsigned SPS   = DEF_SPS,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                bit_out,
    output logic                bit_valid
);

    localparam int unsigned CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum_c;

    // Sign-extended running sum including the sample currently offered.
    assign sum_c = acc + {{(ACC_W-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};

    // Accumulate, dump on the last sample of each symbol.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (sample_valid) begin
                if (cnt == CNT_W'(SPS - 1)) begin
                    bit_out   <= ~sum_c[ACC_W-1];
                    bit_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum_c;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/awgn_rx_detector.sv
// Receive end of the AWGN channel model: slices symbols, hunts for the sync
// word, then packs PAYLOAD_BYTES bytes MSB-first onto a valid/ready port.
//   clk, reset_n           : clock, async active-low reset
//   sample_in/sample_valid : noisy signed channel samples
//   resync                 : synchronous abort back to HUNT, clears data_valid/overflow
//   data_out/data_valid    : payload byte port, consumed when data_ready is high
//   locked                 : high while in LOCK
//   overflow               : sticky, a completed byte was dropped under backpressure
module awgn_rx_detector
    import rx_pkg::*;
#(
    parameter int unsigned          SPS           = DEF_SPS,
    parameter int unsigned          ACC_W         = DEF_ACC_W,
    parameter int unsigned          SYNC_W        = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0]    SYNC_WORD     = SYNC_W'(DEF_SYNC_WORD),
    parameter int unsigned          PAYLOAD_BYTES = DEF_PAYLOAD_BYTES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                resync,
    output logic [BYTE_W-1:0]   data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                locked,
    output logic                overflow
);

    localparam int unsigned BIT_CNT_W  = $clog2(BYTE_W);
    localparam int unsigned BYTE_CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(PAYLOAD_BYTES - 1);

    logic                  bit_out;
    logic                  bit_valid;

    rx_state_t             state, state_d;
    logic [SYNC_W-1:0]     sreg, sreg_d;
    logic [BYTE_W-1:0]     byte_reg, byte_reg_d;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_d;
    logic                  byte_done_c;
    logic [BYTE_W-1:0]     byte_val_c;

    integrate_dump #(
        .SPS   (SPS),
        .ACC_W (ACC_W)
    ) u_integrate (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (resync),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid)
    );

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HUNT;
            sreg     <= '0;
            byte_reg <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_d;
            sreg     <= sreg_d;
            byte_reg <= byte_reg_d;
            bit_cnt  <= bit_cnt_d;
            byte_cnt <= byte_cnt_d;
            locked   <= (state_d == LOCK);
        end
    end

    // Next-state: sync hunt in HUNT, MSB-first byte packing in LOCK.
    always_comb begin
        state_d     = state;
        sreg_d      = sreg;
        byte_reg_d  = byte_reg;
        bit_cnt_d   = bit_cnt;
        byte_cnt_d  = byte_cnt;
        byte_done_c = 1'b0;
        byte_val_c  = {byte_reg[BYTE_W-2:0], bit_out};

        if (resync) begin
            state_d    = HUNT;
            sreg_d     = '0;
            byte_reg_d = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (bit_valid) begin
            unique case (state)
                HUNT: begin
                    sreg_d = {sreg[SYNC_W-2:0], bit_out};
                    // The final sync bit only triggers LOCK; it is not payload.
                    if (sreg_d == SYNC_WORD) begin
                        state_d    = LOCK;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                LOCK: begin
                    byte_reg_d = byte_val_c;
                    bit_cnt_d  = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
                        byte_done_c = 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            state_d    = HUNT;
                            sreg_d     = '0;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt + BYTE_CNT_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Single-entry output register; a byte arriving while full and stalled is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (resync) begin
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (byte_done_c) begin
            if (!data_valid || data_ready) begin
                data_out   <= byte_val_c;
                data_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule
